// File: rtl/timer_pkg.sv
// Shared time-base definitions: default half widths and the tick source selector.
package timer_pkg;

    localparam int TB_LO_W_DFLT = 32;
    localparam int TB_HI_W_DFLT = 32;

    typedef enum logic {
        TB_SRC_CORE = 1'b0,
        TB_SRC_EXT  = 1'b1
    } tb_src_e;

endpackage

// File: rtl/timer_tick_sync.sv
// Brings the asynchronous external time-base clock into the CB domain and
// emits a one-cycle pulse per rising edge.
module timer_tick_sync #(
    parameter int EXT_SYNC = 2
) (
    input  logic CB,
    input  logic resetNEG,
    input  logic ext_i,
    output logic tick_o
);

    logic [EXT_SYNC-1:0] sync_q;
    logic                edge_q;

    always_ff @(posedge CB or negedge resetNEG) begin
        if (!resetNEG) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[EXT_SYNC-2:0], ext_i};
            edge_q <= sync_q[EXT_SYNC-1];
        end
    end

    assign tick_o = sync_q[EXT_SYNC-1] & ~edge_q;

endmodule

// File: rtl/timer_tb_counter.sv
// Two-half time base (TBL/TBU) with SPR write/read path, freeze and an
// optionally registered carry from TBL into TBU.
module timer_tb_counter
    import timer_pkg::*;
#(
    parameter int LO_W     = TB_LO_W_DFLT,
    parameter int HI_W     = TB_HI_W_DFLT,
    parameter int PIPE_CRY = 1,
    parameter int EXT_SYNC = 2
) (
    input  logic            CB,
    input  logic            resetNEG,
    input  logic            tbSrcSel,
    input  logic            tbIncCore,
    input  logic            tbExtClk,
    input  logic            freezeTimersNEG,
    input  logic            PCL_mtSPR,
    input  logic            PCL_sprHold,
    input  logic            tblDcd,
    input  logic            tbhDcd,
    input  logic [31:0]     sprWrData,
    output logic [LO_W-1:0] tbl,
    output logic [HI_W-1:0] tbh,
    output logic [31:0]     sprRdData,
    output logic            tbCarryPend,
    output logic            tbWrap
);

    logic [LO_W-1:0] tbl_q, tbl_d;
    logic [HI_W-1:0] tbh_q, tbh_d;
    logic            pend_q, pend_d;
    logic            wrap_q, wrap_d;

    logic    ext_tick, tick, inc, wr_l, wr_h, cry, tbh_inc;
    tb_src_e src;

    timer_tick_sync #(.EXT_SYNC(EXT_SYNC)) u_sync (
        .CB       (CB),
        .resetNEG (resetNEG),
        .ext_i    (tbExtClk),
        .tick_o   (ext_tick)
    );

    assign src  = tb_src_e'(tbSrcSel);
    assign tick = (src == TB_SRC_EXT) ? ext_tick : tbIncCore;
    assign inc  = tick & freezeTimersNEG;
    assign wr_l = PCL_mtSPR & tblDcd & ~PCL_sprHold;
    assign wr_h = PCL_mtSPR & tbhDcd & ~PCL_sprHold;
    assign cry  = inc & ~wr_l & (tbl_q == '1);

    // Pipelined mode consumes the carry one cycle after the wrap, and only while unfrozen.
    assign tbh_inc = (PIPE_CRY != 0) ? (pend_q & freezeTimersNEG) : cry;

    always_comb begin
        tbl_d  = tbl_q;
        tbh_d  = tbh_q;
        pend_d = 1'b0;
        wrap_d = 1'b0;
        if (wr_l) begin
            tbl_d = sprWrData[LO_W-1:0];
        end else if (inc) begin
            tbl_d = tbl_q + LO_W'(1);
        end
        if (wr_h) begin
            tbh_d = sprWrData[HI_W-1:0];
        end else if (tbh_inc) begin
            tbh_d  = tbh_q + HI_W'(1);
            wrap_d = (tbh_q == '1);
        end
        if (PIPE_CRY != 0) begin
            if (cry) begin
                pend_d = 1'b1;
            end else if (wr_h || freezeTimersNEG) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    always_ff @(posedge CB or negedge resetNEG) begin
        if (!resetNEG) begin
            tbl_q  <= '0;
            tbh_q  <= '0;
            pend_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tbl_q  <= tbl_d;
            tbh_q  <= tbh_d;
            pend_q <= pend_d;
            wrap_q <= wrap_d;
        end
    end

    // TBU reads include an in-flight carry so software sees a coherent 64-bit value.
    always_comb begin
        sprRdData = '0;
        if (tblDcd) begin
            sprRdData[LO_W-1:0] = tbl_q;
        end else if (tbhDcd) begin
            sprRdData[HI_W-1:0] = tbh_q + HI_W'(pend_q);
        end
    end

    assign tbl         = tbl_q;
    assign tbh         = tbh_q;
    assign tbCarryPend = pend_q;
    assign tbWrap      = wrap_q;

endmodule

// File: tb/tb_timer_tb_counter.sv
// Directed bench for timer_tb_counter: a vector table for single-cycle
// behaviour plus hand-written reset, freeze, external-tick and TBU-wrap sequences.
module tb_timer_tb_counter;

    localparam int EXT_SYNC = 2;

    logic        CB = 1'b0;
    logic        resetNEG;
    logic        tbSrcSel, tbIncCore, tbExtClk, freezeTimersNEG;
    logic        PCL_mtSPR, PCL_sprHold, tblDcd, tbhDcd;
    logic [31:0] sprWrData;

    logic [31:0] tbl1, tbh1, rd1, tbl0, tbh0, rd0;
    logic        pend1, wrap1, pend0, wrap0;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    timer_tb_counter #(.LO_W(32), .HI_W(32), .PIPE_CRY(1), .EXT_SYNC(EXT_SYNC)) dut (
        .CB(CB), .resetNEG(resetNEG), .tbSrcSel(tbSrcSel), .tbIncCore(tbIncCore),
        .tbExtClk(tbExtClk), .freezeTimersNEG(freezeTimersNEG), .PCL_mtSPR(PCL_mtSPR),
        .PCL_sprHold(PCL_sprHold), .tblDcd(tblDcd), .tbhDcd(tbhDcd), .sprWrData(sprWrData),
        .tbl(tbl1), .tbh(tbh1), .sprRdData(rd1), .tbCarryPend(pend1), .tbWrap(wrap1)
    );

    timer_tb_counter #(.LO_W(32), .HI_W(32), .PIPE_CRY(0), .EXT_SYNC(EXT_SYNC)) dut0 (
        .CB(CB), .resetNEG(resetNEG), .tbSrcSel(tbSrcSel), .tbIncCore(tbIncCore),
        .tbExtClk(tbExtClk), .freezeTimersNEG(freezeTimersNEG), .PCL_mtSPR(PCL_mtSPR),
        .PCL_sprHold(PCL_sprHold), .tblDcd(tblDcd), .tbhDcd(tbhDcd), .sprWrData(sprWrData),
        .tbl(tbl0), .tbh(tbh0), .sprRdData(rd0), .tbCarryPend(pend0), .tbWrap(wrap0)
    );

    // clock
    always #5 CB = ~CB;

    typedef struct packed {
        logic        mt, tl, th, hold, inc, frz;
        logic [31:0] data;
        logic [31:0] e_tbl, e_tbh;
        logic        e_pend, e_wrap;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic mt, tl, th, hold, inc, frz, input logic [31:0] data,
                                input logic [31:0] e_tbl, e_tbh, input logic e_pend, e_wrap,
                                input logic [31:0] e_rd);
        vec_t v;
        v.mt = mt; v.tl = tl; v.th = th; v.hold = hold; v.inc = inc; v.frz = frz;
        v.data = data; v.e_tbl = e_tbl; v.e_tbh = e_tbh; v.e_pend = e_pend;
        v.e_wrap = e_wrap; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CB);
        #1;
    endtask

    task automatic drive(input logic mt, tl, th, hold, inc, frz, input logic [31:0] data);
        PCL_mtSPR = mt; tblDcd = tl; tbhDcd = th; PCL_sprHold = hold;
        tbIncCore = inc; freezeTimersNEG = frz; sprWrData = data;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 1, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        tbSrcSel = 1'b0;
        tbExtClk = 1'b0;
        resetNEG = 1'b0;
        step();
        step();
        resetNEG = 1'b1;
        step();
    endtask

    initial begin
        int first_chg;
        logic [31:0] prev;

        //                mt tl th hd in fz  data          e_tbl         e_tbh         pd wr e_rd
        vecs[0]  = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'h1,        32'h0,        0, 0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0,       0, 0, 32'hFFFF_FFFE);
        vecs[2]  = mk(0, 1, 0, 0, 1, 1, 32'h0,        32'hFFFF_FFFF, 32'h0,        0, 0, 32'hFFFF_FFFF);
        vecs[3]  = mk(0, 0, 1, 0, 1, 1, 32'h0,        32'h0,        32'h0,        1, 0, 32'h1);
        vecs[4]  = mk(0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h1,        0, 0, 32'h1);
        vecs[5]  = mk(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,       0, 0, 32'hFFFF_FFFF);
        vecs[6]  = mk(0, 0, 1, 0, 1, 1, 32'h0,        32'h0,        32'h1,        1, 0, 32'h2);
        vecs[7]  = mk(0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h1,        1, 0, 32'h2);
        vecs[8]  = mk(0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h1,        1, 0, 32'h2);
        vecs[9]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h1,        1, 0, 32'h2);
        vecs[10] = mk(0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h2,        0, 0, 32'h2);
        vecs[11] = mk(1, 1, 0, 0, 1, 1, 32'h1234_5678, 32'h1234_5678, 32'h2,       0, 0, 32'h1234_5678);
        vecs[12] = mk(1, 1, 0, 1, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h2,       0, 0, 32'h1234_5678);
        vecs[13] = mk(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2,       0, 0, 32'hFFFF_FFFF);
        vecs[14] = mk(0, 0, 1, 0, 1, 1, 32'h0,        32'h0,        32'h2,        1, 0, 32'h3);
        vecs[15] = mk(1, 0, 1, 0, 0, 1, 32'h0000_00AA, 32'h0,       32'hAA,       0, 0, 32'hAA);
        vecs[16] = mk(0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'hAA,       0, 0, 32'hAA);
        vecs[17] = mk(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAA,      0, 0, 32'hFFFF_FFFF);
        vecs[18] = mk(1, 1, 0, 0, 1, 1, 32'h5,        32'h5,        32'hAA,       0, 0, 32'h5);
        vecs[19] = mk(1, 0, 1, 1, 0, 1, 32'h77,       32'h5,        32'hAA,       0, 0, 32'hAA);
        vecs[20] = mk(1, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'h5,       32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        vecs[21] = mk(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        vecs[22] = mk(0, 0, 1, 0, 1, 1, 32'h0,        32'h0,        32'hFFFF_FFFF, 1, 0, 32'h0);
        vecs[23] = mk(0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0);
        vecs[24] = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
        vecs[25] = mk(1, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0,       32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        vecs[26] = mk(1, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
        vecs[27] = mk(1, 1, 0, 0, 0, 1, 32'h42,       32'h42,       32'h0,        0, 0, 32'h42);
        vecs[28] = mk(0, 1, 1, 0, 0, 1, 32'h0,        32'h42,       32'h0,        0, 0, 32'h42);

        // reset state
        do_reset();
        tbhDcd = 1'b1;
        #1;
        chk("reset_tbl", tbl1, 32'h0);
        chk("reset_tbh", tbh1, 32'h0);
        chk("reset_pend", {31'b0, pend1}, 32'h0);
        chk("reset_wrap", {31'b0, wrap1}, 32'h0);
        chk("reset_rd", rd1, 32'h0);

        // vector table
        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].mt, vecs[i].tl, vecs[i].th, vecs[i].hold, vecs[i].inc,
                  vecs[i].frz, vecs[i].data);
            step();
            chk($sformatf("vec%0d_tbl", i), tbl1, vecs[i].e_tbl);
            chk($sformatf("vec%0d_tbh", i), tbh1, vecs[i].e_tbh);
            chk($sformatf("vec%0d_pend", i), {31'b0, pend1}, {31'b0, vecs[i].e_pend});
            chk($sformatf("vec%0d_wrap", i), {31'b0, wrap1}, {31'b0, vecs[i].e_wrap});
            chk($sformatf("vec%0d_rd", i), rd1, vecs[i].e_rd);
        end

        // reset mid-operation with a carry pending
        drive(1, 0, 1, 0, 0, 1, 32'h55); step();
        drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF); step();
        drive(0, 0, 1, 0, 1, 1, 32'h0); step();
        chk("prerst_pend", {31'b0, pend1}, 32'h1);
        chk("prerst_rd", rd1, 32'h56);
        #2;
        resetNEG = 1'b0;
        #1;
        chk("midrst_tbl", tbl1, 32'h0);
        chk("midrst_tbh", tbh1, 32'h0);
        chk("midrst_pend", {31'b0, pend1}, 32'h0);
        chk("midrst_rd", rd1, 32'h0);
        do_reset();

        // frozen with a carry pending: ticks dropped, carry held
        drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF); step();
        drive(0, 0, 0, 0, 1, 1, 32'h0); step();
        chk("frz_setpend", {31'b0, pend1}, 32'h1);
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 1, 0, 32'h0);
            step();
            chk($sformatf("frz%0d_tbl", c), tbl1, 32'h0);
            chk($sformatf("frz%0d_tbh", c), tbh1, 32'h0);
            chk($sformatf("frz%0d_pend", c), {31'b0, pend1}, 32'h1);
        end
        idle(); step();
        chk("unfrz_tbh", tbh1, 32'h1);
        chk("unfrz_pend", {31'b0, pend1}, 32'h0);
        chk("unfrz_tbl", tbl1, 32'h0);

        // external tick source at CB/4; core ticks must be ignored
        do_reset();
        tbSrcSel  = 1'b1;
        tbIncCore = 1'b1;
        for (int k = 1; k <= 5; k++) exp_q.push_back(32'(k));
        first_chg = -1;
        prev = tbl1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tbExtClk = (cyc < 20) && ((cyc % 4) < 2);
            step();
            if (tbl1 !== prev) begin
                if (first_chg < 0) first_chg = cyc;
                if (exp_q.size() == 0) begin
                    chk("ext_extra_tick", tbl1, prev);
                end else begin
                    chk($sformatf("ext_tbl_c%0d", cyc), tbl1, exp_q.pop_front());
                end
                prev = tbl1;
            end
        end
        chk("ext_latency", 32'(first_chg + 1), 32'(EXT_SYNC + 1));
        chk("ext_q_empty", 32'(exp_q.size()), 32'h0);
        chk("ext_final_tbl", tbl1, 32'h5);
        chk("ext_final_tbl_nopipe", tbl0, 32'h5);

        // TBU all-ones wrap, pipelined vs same-cycle carry
        do_reset();
        drive(1, 0, 1, 0, 0, 1, 32'hFFFF_FFFF); step();
        drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF); step();
        drive(0, 0, 0, 0, 1, 1, 32'h0); step();
        chk("wrapA_tbl", tbl1, 32'h0);
        chk("wrapA_tbh", tbh1, 32'hFFFF_FFFF);
        chk("wrapA_pend", {31'b0, pend1}, 32'h1);
        chk("wrapA_wrap", {31'b0, wrap1}, 32'h0);
        chk("wrapA_tbl_np", tbl0, 32'h0);
        chk("wrapA_tbh_np", tbh0, 32'h0);
        chk("wrapA_pend_np", {31'b0, pend0}, 32'h0);
        chk("wrapA_wrap_np", {31'b0, wrap0}, 32'h1);
        idle(); step();
        chk("wrapB_tbh", tbh1, 32'h0);
        chk("wrapB_pend", {31'b0, pend1}, 32'h0);
        chk("wrapB_wrap", {31'b0, wrap1}, 32'h1);
        chk("wrapB_wrap_np", {31'b0, wrap0}, 32'h0);
        step();
        chk("wrapC_wrap", {31'b0, wrap1}, 32'h0);
        chk("wrapC_tbh_np", tbh0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
